mul_arbiter_ctrl: RTL and testbench

Sequencing controller and two-port arbiter for the shared iterative Booth radix-4 multiplication unit. Two requesters issue multiply operations through valid/ready handshakes: port 0 is the integer execute issue path and port 1 is the auxiliary or FPU mantissa path. The block grants one request round-robin and holds the operands stable for the unit's full iteration. It gates the unit's clock enable, captures the product and returns it through a tagged valid/ready response channel.

---
 rtl/mul_arbiter_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mul_arbiter_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_ctrl.sv
// mul_arbiter_ctrl
// Two-port round-robin arbiter and sequencer for the shared iterative Booth
// radix-4 multiplication unit. A granted request's operands are latched and
// held for the unit's full iteration. The unit's clock enable is gated, and
// its result is captured and returned on a tagged valid/ready channel.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               discard the pending/in-flight operation
//   reqN_*                port N request: valid/ready, operands a/b, op, tag
//   rsp_*                 response: valid/ready, originating port, tag, data
//   mul_a_o/b_o/op_o      held operands/operation to the unit
//   mul_clk_en_o          unit clock enable (high only while iterating)
//   mul_result_i          unit result

package mul_arbiter_pkg;
  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHU_  = 2'd2,
    MULHSU_ = 2'd3
  } mul_ops_e;
endpackage

module mul_arbiter_ctrl
  import mul_arbiter_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned MUL_LATENCY = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [XLEN-1:0]  req0_a_i,
  input  logic [XLEN-1:0]  req0_b_i,
  input  mul_ops_e         req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [XLEN-1:0]  req1_a_i,
  input  logic [XLEN-1:0]  req1_b_i,
  input  mul_ops_e         req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_port_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic [XLEN-1:0]  rsp_data_o,

  output logic [XLEN-1:0]  mul_a_o,
  output logic [XLEN-1:0]  mul_b_o,
  output mul_ops_e         mul_op_o,
  output logic             mul_clk_en_o,
  input  logic [XLEN-1:0]  mul_result_i
);

  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    CAPTURE,
    RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_grant_q;
  logic [XLEN-1:0]  a_q, b_q, data_q;
  mul_ops_e         op_q;
  logic [TAG_W-1:0] tag_q;
  logic             port_q;

  logic             grant_port;
  logic             hs;
  logic             capture;

  // Sole valid port wins; on contention the port that did not win last time.
  always_comb begin
    grant_port = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_port = ~last_grant_q;
    end else if (req1_valid_i) begin
      grant_port = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    mul_clk_en_o = 1'b0;
    rsp_valid_o  = 1'b0;
    hs           = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i && !rst_i) begin
          req0_ready_o = req0_valid_i & ~grant_port;
          req1_ready_o = req1_valid_i & grant_port;
          hs           = req0_valid_i | req1_valid_i;
          if (hs) state_d = RUN;
        end
      end
      RUN: begin
        mul_clk_en_o = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = flush_i ? IDLE : CAPTURE;
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end
      // Keep clocking the unit so its step counter wraps back to zero.
      DRAIN: begin
        mul_clk_en_o = 1'b1;
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      CAPTURE: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= MUL_;
      tag_q        <= '0;
      port_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        a_q          <= grant_port ? req1_a_i   : req0_a_i;
        b_q          <= grant_port ? req1_b_i   : req0_b_i;
        op_q         <= grant_port ? req1_op_i  : req0_op_i;
        tag_q        <= grant_port ? req1_tag_i : req0_tag_i;
        port_q       <= grant_port;
        last_grant_q <= grant_port;
        cnt_q        <= '0;
      end else if (mul_clk_en_o) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) data_q <= mul_result_i;
    end
  end

  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;
  assign mul_op_o   = op_q;
  assign rsp_tag_o  = tag_q;
  assign rsp_port_o = port_q;
  assign rsp_data_o = data_q;

endmodule

// File: tb/tb_mul_arbiter_ctrl.sv
module tb_mul_arbiter_ctrl;
  import mul_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  mul_ops_e    req0_op_i = MUL_, req1_op_i = MUL_;
  logic [4:0]  req0_tag_i = '0, req1_tag_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_port_o;
  logic [4:0]  rsp_tag_o;
  logic [31:0] rsp_data_o, mul_a_o, mul_b_o, mul_result_i;
  mul_ops_e    mul_op_o;
  logic        mul_clk_en_o;

  always #5 clk = ~clk;

  mul_arbiter_ctrl #(.XLEN(32), .TAG_W(5), .MUL_LATENCY(17)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_a_i(req0_a_i),
    .req0_b_i(req0_b_i), .req0_op_i(req0_op_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_a_i(req1_a_i),
    .req1_b_i(req1_b_i), .req1_op_i(req1_op_i), .req1_tag_i(req1_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_port_o(rsp_port_o),
    .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o), .mul_op_o(mul_op_o),
    .mul_clk_en_o(mul_clk_en_o), .mul_result_i(mul_result_i)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input mul_ops_e op);
    logic [63:0] ea, eb, p;
    ea = (op == MULH_ || op == MULHSU_) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == MULH_) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == MUL_) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiplier unit: loads on its step 0, result valid only after
  // 17 enabled cycles; poisoned in between so early capture is visible.
  logic [4:0]  ucnt;
  logic [31:0] ureg, ua, ub;
  mul_ops_e    uop;
  always @(posedge clk) begin
    if (rst_i) begin
      ucnt <= '0; ureg <= '0; ua <= '0; ub <= '0; uop <= MUL_;
    end else if (mul_clk_en_o) begin
      if (ucnt == 5'd0) begin
        ua <= mul_a_o; ub <= mul_b_o; uop <= mul_op_o; ureg <= 32'hDEADBEEF;
      end
      if (ucnt == 5'd16) ureg <= ref_mul(ua, ub, uop);
      ucnt <= (ucnt == 5'd16) ? 5'd0 : ucnt + 5'd1;
    end
  end
  assign mul_result_i = ureg;

  // Transaction-level reference: phase = cycles since the accepting handshake.
  bit          m_busy = 0, m_fl = 0, m_last = 1, m_port = 0;
  int          m_ph = 0;
  logic [31:0] m_a = '0, m_b = '0, m_exp = '0;
  mul_ops_e    m_op = MUL_;
  logic [4:0]  m_tag = '0;

  int          cyc = 0, hs_cyc = 0, rsp_cyc = 0;
  bit          hs_ev, rsp_ev;
  logic [31:0] rsp_d;
  logic [4:0]  rsp_t;
  logic        rsp_p;

  task automatic tick();
    logic gp, e_r0, e_r1, e_en, e_v, s_r0, s_r1;
    hs_ev = 0; rsp_ev = 0;
    #1;
    gp   = (req0_valid_i && req1_valid_i) ? ~m_last : req1_valid_i;
    e_r0 = !m_busy && !flush_i && req0_valid_i && !gp;
    e_r1 = !m_busy && !flush_i && req1_valid_i && gp;
    e_en = m_busy && m_ph >= 1 && m_ph <= 17;
    e_v  = m_busy && !m_fl && m_ph >= 19;
    if (!rst_i) begin
      check_val("req0_ready", 32'(req0_ready_o), 32'(e_r0));
      check_val("req1_ready", 32'(req1_ready_o), 32'(e_r1));
      check_val("clk_en", 32'(mul_clk_en_o), 32'(e_en));
      check_val("rsp_valid", 32'(rsp_valid_o), 32'(e_v));
      check_val("mul_a", mul_a_o, m_a);
      check_val("mul_b", mul_b_o, m_b);
      check_val("mul_op", 32'(mul_op_o), 32'(m_op));
      if (e_v) begin
        check_val("rsp_data", rsp_data_o, m_exp);
        check_val("rsp_tag", 32'(rsp_tag_o), 32'(m_tag));
        check_val("rsp_port", 32'(rsp_port_o), 32'(m_port));
      end
      if (!e_en) check_val("unit_cnt_zero", 32'(ucnt), 32'd0);
    end
    s_r0 = req0_ready_o; s_r1 = req1_ready_o;
    if (rsp_valid_o && rsp_ready_i && !flush_i) begin
      rsp_ev = 1; rsp_cyc = cyc; rsp_d = rsp_data_o; rsp_t = rsp_tag_o; rsp_p = rsp_port_o;
    end
    if (s_r0 || s_r1) begin hs_ev = 1; hs_cyc = cyc; end
    @(posedge clk);
    if (rst_i) begin
      m_busy = 0; m_last = 1; m_a = '0; m_b = '0; m_op = MUL_; m_tag = '0; m_port = 0;
    end else if (!m_busy) begin
      if (e_r0 || e_r1) begin
        m_busy = 1; m_ph = 1; m_fl = 0; m_port = gp; m_last = gp;
        m_a   = gp ? req1_a_i : req0_a_i;
        m_b   = gp ? req1_b_i : req0_b_i;
        m_op  = gp ? req1_op_i : req0_op_i;
        m_tag = gp ? req1_tag_i : req0_tag_i;
        m_exp = ref_mul(m_a, m_b, m_op);
      end
    end else begin
      if (flush_i && !m_fl) begin
        if (m_ph <= 17) m_fl = 1;
        else m_busy = 0;
      end
      if (m_busy && m_fl && m_ph == 17) m_busy = 0;
      if (m_busy && !m_fl && m_ph >= 19 && rsp_ready_i) m_busy = 0;
      m_ph++;
    end
    cyc++;
    @(negedge clk);
    if (s_r0) req0_valid_i = 0;
    if (s_r1) req1_valid_i = 0;
  endtask

  task automatic wait_hs(input string tag);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (hs_ev) return;
    end
    check_val({tag, "_hs_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (rsp_ev) return;
    end
    check_val({tag, "_rsp_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    req0_valid_i = 0; req1_valid_i = 0; flush_i = 0; rst_i = 1;
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    #1;
    check_val({tag, "_rst_valid"}, 32'(rsp_valid_o), 32'd0);
    check_val({tag, "_rst_clk_en"}, 32'(mul_clk_en_o), 32'd0);
    check_val({tag, "_rst_ready0"}, 32'(req0_ready_o), 32'd0);
    check_val({tag, "_rst_mul_a"}, mul_a_o, 32'd0);
    check_val({tag, "_rst_data"}, rsp_data_o, 32'd0);
    check_val({tag, "_rst_tag"}, 32'(rsp_tag_o), 32'd0);
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                         input mul_ops_e op, input logic [4:0] tag);
    if (p == 0) begin
      req0_a_i = a; req0_b_i = b; req0_op_i = op; req0_tag_i = tag; req0_valid_i = 1;
    end else begin
      req1_a_i = a; req1_b_i = b; req1_op_i = op; req1_tag_i = tag; req1_valid_i = 1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    check_reset_vals("t0");

    // basic MUL and latency
    rsp_ready_i = 1;
    set_req(0, 32'd7, 32'd6, MUL_, 5'd3);
    wait_hs("t1");
    wait_rsp("t1");
    check_val("t1_data", rsp_d, 32'd42);
    check_val("t1_tag", 32'(rsp_t), 32'd3);
    check_val("t1_port", 32'(rsp_p), 32'd0);
    check_val("t1_latency", 32'(rsp_cyc - hs_cyc), 32'd19);

    // contention and alternation
    do_reset();
    rsp_ready_i = 1;
    set_req(0, 32'd2, 32'd3, MUL_, 5'd1);
    set_req(1, 32'd4, 32'd5, MUL_, 5'd2);
    wait_rsp("t2a");
    check_val("t2a_port", 32'(rsp_p), 32'd0);
    check_val("t2a_data", rsp_d, 32'd6);
    wait_rsp("t2b");
    check_val("t2b_port", 32'(rsp_p), 32'd1);
    check_val("t2b_data", rsp_d, 32'd20);
    set_req(0, 32'd2, 32'd3, MUL_, 5'd1);
    set_req(1, 32'd4, 32'd5, MUL_, 5'd2);
    wait_rsp("t2c");
    check_val("t2c_port", 32'(rsp_p), 32'd0);
    wait_rsp("t2d");
    check_val("t2d_port", 32'(rsp_p), 32'd1);

    // signed high word
    set_req(0, 32'hFFFFFFFD, 32'd5, MULH_, 5'd4);
    wait_hs("t3");
    wait_rsp("t3");
    check_val("t3_data", rsp_d, 32'hFFFFFFFF);
    check_val("t3_latency", 32'(rsp_cyc - hs_cyc), 32'd19);

    // response backpressure
    rsp_ready_i = 0;
    set_req(0, 32'd9, 32'd9, MUL_, 5'd9);
    wait_hs("t4");
    set_req(1, 32'd2, 32'd8, MUL_, 5'd4);
    for (int i = 0; i < 40 && !rsp_valid_o; i++) tick();
    check_val("t4_valid_seen", 32'(rsp_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t4_hold", rsp_data_o, 32'd81);
    end
    rsp_ready_i = 1;
    tick();
    check_val("t4_rsp_hs", 32'(rsp_ev), 32'd1);
    tick();
    check_val("t4_req1_hs", 32'(hs_ev), 32'd1);
    check_val("t4_req1_gap", 32'(hs_cyc - rsp_cyc), 32'd1);
    wait_rsp("t4b");
    check_val("t4b_data", rsp_d, 32'd16);
    check_val("t4b_port", 32'(rsp_p), 32'd1);

    // flush during RUN
    set_req(0, 32'd1, 32'd1, MUL_, 5'd1);
    wait_hs("t5");
    for (int i = 0; i < 4; i++) tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      check_val("t5_no_rsp", 32'(rsp_ev), 32'd0);
    end
    set_req(0, 32'd11, 32'd3, MUL_, 5'd5);
    wait_hs("t5b");
    wait_rsp("t5b");
    check_val("t5b_data", rsp_d, 32'd33);
    check_val("t5b_latency", 32'(rsp_cyc - hs_cyc), 32'd19);

    // reset mid-RUN
    set_req(0, 32'd3, 32'd3, MUL_, 5'd6);
    wait_hs("t6");
    for (int i = 0; i < 7; i++) tick();
    rst_i = 1;
    tick();
    rst_i = 0;
    check_reset_vals("t6");
    set_req(0, 32'd5, 32'd5, MUL_, 5'd7);
    wait_hs("t6b");
    wait_rsp("t6b");
    check_val("t6b_data", rsp_d, 32'd25);
    check_val("t6b_latency", 32'(rsp_cyc - hs_cyc), 32'd19);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid_i && $urandom_range(0, 3) == 0)
        set_req(0, $urandom, $urandom, mul_ops_e'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      if (!req1_valid_i && $urandom_range(0, 3) == 0)
        set_req(1, $urandom, $urandom, mul_ops_e'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      flush_i     = ($urandom_range(0, 29) == 0);
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
